// File: rtl/vector_player.sv
// Replays stored {rst, in} vectors into an FSM under test, STEP cycles per vector.
// Optional response signature over dut_out is built when VECTOR_PLAYER_SIG_EN is defined.
module vector_player #(
    parameter int IN_W   = 7,
    parameter int OUT_W  = 19,
    parameter int DEPTH  = 125,
    parameter int ADDR_W = 7,
    parameter int STEP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [IN_W:0]     load_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   play_len,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              dut_rst,
    output logic [IN_W-1:0]   dut_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] vec_idx,
    output logic [7:0]        loop_cnt,
    output logic [OUT_W-1:0]  signature
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int HOLD_W = (STEP > 1) ? $clog2(STEP) : 1;

    state_t            state;
    logic [IN_W:0]     mem [DEPTH];
    logic [HOLD_W-1:0] hold;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len;
    logic              final_hold;
    logic              last_idx;

    assign final_hold = (hold == HOLD_W'(STEP - 1));
    assign last_idx   = ({1'b0, idx} == (len - 1'b1));

    // Vector memory has no reset; writes are accepted only while idle.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && load_we && 32'(load_addr) < DEPTH)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            idx      <= '0;
            len      <= '0;
            dut_rst  <= 1'b1;
            dut_in   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            vec_idx  <= '0;
            loop_cnt <= '0;
`ifdef VECTOR_PLAYER_SIG_EN
            signature <= '0;
`endif
        end else begin
            // Output stage lags the sequencer by one cycle; stop blanks it immediately.
            done <= (state == DONE);
            if (state == RUN && !stop) begin
                {dut_rst, dut_in} <= mem[idx];
                vec_idx           <= idx;
            end else begin
                dut_rst <= 1'b1;
                dut_in  <= '0;
                vec_idx <= '0;
            end

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (play_len == '0) begin
                            state <= DONE;
                        end else begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            idx      <= '0;
                            hold     <= '0;
                            loop_cnt <= '0;
                            len      <= (32'(play_len) > DEPTH) ? (ADDR_W+1)'(DEPTH) : play_len;
`ifdef VECTOR_PLAYER_SIG_EN
                            signature <= '0;
`endif
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (final_hold) begin
                        hold <= '0;
`ifdef VECTOR_PLAYER_SIG_EN
                        signature <= {signature[OUT_W-2:0], signature[OUT_W-1]} ^ dut_out;
`endif
                        if (last_idx) begin
                            idx <= '0;
                            if (loop_cnt != 8'hFF)
                                loop_cnt <= loop_cnt + 8'd1;
                            if (!loop_en) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef VECTOR_PLAYER_SIG_EN
    logic sig_unused;
    assign sig_unused = ^dut_out;
    assign signature  = '0;
`endif

endmodule

// File: tb/tb_vector_player.sv
// Bench for vector_player: two instances (STEP=1 and STEP=4) checked every cycle
// against a position-based playback model, plus directed literal expectations.
module tb_vector_player;

    localparam int DEPTH = 125;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [6:0]  load_addr;
    logic [7:0]  load_data;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [7:0]  play_len;
    logic [18:0] dut_out;

    logic        dr [2];
    logic [6:0]  din [2];
    logic        bz [2];
    logic        dn [2];
    logic [6:0]  vi [2];
    logic [7:0]  lc [2];
    logic [18:0] sg [2];

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    vector_player #(.IN_W(7), .OUT_W(19), .DEPTH(DEPTH), .ADDR_W(7), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .start(start), .stop(stop), .loop_en(loop_en), .play_len(play_len), .dut_out(dut_out),
        .dut_rst(dr[0]), .dut_in(din[0]), .busy(bz[0]), .done(dn[0]), .vec_idx(vi[0]),
        .loop_cnt(lc[0]), .signature(sg[0])
    );

    vector_player #(.IN_W(7), .OUT_W(19), .DEPTH(DEPTH), .ADDR_W(7), .STEP(4)) u4 (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .start(start), .stop(stop), .loop_en(loop_en), .play_len(play_len), .dut_out(dut_out),
        .dut_rst(dr[1]), .dut_in(din[1]), .busy(bz[1]), .done(dn[1]), .vec_idx(vi[1]),
        .loop_cnt(lc[1]), .signature(sg[1])
    );

    // Model: mode 0=idle, 1=playing, 2=finishing; pos counts cycles into the current pass.
    int          mode [2];
    int          pos  [2];
    int          len  [2];
    int          lcnt [2];
    logic [18:0] sig  [2];
    logic [7:0]  mm   [2][DEPTH];
    logic        e_rst [2];
    logic [6:0]  e_in  [2];
    logic        e_busy[2];
    logic        e_done[2];
    logic [6:0]  e_idx [2];
    logic [7:0]  e_lc  [2];
    logic [18:0] e_sig [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input int s);
        logic [7:0] v;
        if (rst) begin
            mode[i] = 0; pos[i] = 0; len[i] = 0; lcnt[i] = 0; sig[i] = '0;
            e_rst[i] = 1'b1; e_in[i] = '0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_idx[i] = '0;
        end else begin
            e_done[i] = (mode[i] == 2);
            if (mode[i] == 1 && !stop) begin
                v = mm[i][pos[i] / s];
                e_rst[i] = v[7];
                e_in[i]  = v[6:0];
                e_idx[i] = 7'(pos[i] / s);
            end else begin
                e_rst[i] = 1'b1; e_in[i] = '0; e_idx[i] = '0;
            end
            case (mode[i])
                0: begin
                    if (load_we && int'(load_addr) < DEPTH) mm[i][load_addr] = load_data;
                    if (start && !stop) begin
                        if (play_len == 0) mode[i] = 2;
                        else begin
                            mode[i] = 1; pos[i] = 0; lcnt[i] = 0; sig[i] = '0;
                            len[i] = (int'(play_len) > DEPTH) ? DEPTH : int'(play_len);
                        end
                    end
                end
                1: begin
                    if (stop) mode[i] = 0;
                    else begin
`ifdef VECTOR_PLAYER_SIG_EN
                        if (pos[i] % s == s - 1) sig[i] = {sig[i][17:0], sig[i][18]} ^ dut_out;
`endif
                        pos[i]++;
                        if (pos[i] == len[i] * s) begin
                            if (lcnt[i] < 255) lcnt[i]++;
                            pos[i] = 0;
                            if (!loop_en) mode[i] = 2;
                        end
                    end
                end
                default: mode[i] = 0;
            endcase
            e_busy[i] = (mode[i] == 1);
        end
        e_lc[i]  = 8'(lcnt[i]);
        e_sig[i] = sig[i];
    endtask

    always @(posedge clk) begin
        model_step(0, 1);
        model_step(1, 4);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut_rst[%0d]", i),   32'(dr[i]),  32'(e_rst[i]));
                chk($sformatf("dut_in[%0d]", i),    32'(din[i]), 32'(e_in[i]));
                chk($sformatf("busy[%0d]", i),      32'(bz[i]),  32'(e_busy[i]));
                chk($sformatf("done[%0d]", i),      32'(dn[i]),  32'(e_done[i]));
                chk($sformatf("vec_idx[%0d]", i),   32'(vi[i]),  32'(e_idx[i]));
                chk($sformatf("loop_cnt[%0d]", i),  32'(lc[i]),  32'(e_lc[i]));
                chk($sformatf("signature[%0d]", i), 32'(sg[i]),  32'(e_sig[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_dut_rst"}, 32'(dr[i]), 32'd1);
            chk({tag, "_dut_in"},  32'(din[i]), 32'd0);
            chk({tag, "_busy"},    32'(bz[i]), 32'd0);
            chk({tag, "_done"},    32'(dn[i]), 32'd0);
            chk({tag, "_vec_idx"}, 32'(vi[i]), 32'd0);
            chk({tag, "_loop_cnt"},32'(lc[i]), 32'd0);
            chk({tag, "_sig"},     32'(sg[i]), 32'd0);
        end
    endtask

    int bc, dc, hc;
    logic [7:0] first3 [3];

    initial begin
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; play_len = '0; dut_out = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Fill all entries, then the three directed vectors.
        for (int a = 0; a < DEPTH; a++) begin
            load_we = 1'b1; load_addr = 7'(a); load_data = 8'(a * 37 + 5);
            tick();
        end
        first3[0] = 8'h80; first3[1] = 8'h15; first3[2] = 8'h7F;
        for (int a = 0; a < 3; a++) begin
            load_addr = 7'(a); load_data = first3[a];
            tick();
        end
        load_addr = 7'd126; load_data = 8'hEE;
        tick();
        load_we = 1'b0;

        // Three vectors, STEP=1, no loop.
        play_len = 8'd3; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("t1_v0_rst", 32'(dr[0]), 32'd1); chk("t1_v0_in", 32'(din[0]), 32'h00);
        chk("t1_busy", 32'(bz[0]), 32'd1);
        tick();
        chk("t1_v1_rst", 32'(dr[0]), 32'd0); chk("t1_v1_in", 32'(din[0]), 32'h15);
        tick();
        chk("t1_v2_rst", 32'(dr[0]), 32'd0); chk("t1_v2_in", 32'(din[0]), 32'h7F);
        tick();
        chk("t1_done", 32'(dn[0]), 32'd1); chk("t1_loop_cnt", 32'(lc[0]), 32'd1);
        chk("t1_rst_back", 32'(dr[0]), 32'd1); chk("t1_busy_low", 32'(bz[0]), 32'd0);
        tick();
        chk("t1_done_once", 32'(dn[0]), 32'd0);
        repeat (12) tick();

        // STEP=4 instance: two vectors held four cycles each.
        play_len = 8'd2; start = 1'b1;
        tick(); start = 1'b0;
        bc = 0; dc = 0; hc = 0;
        repeat (14) begin
            bc += int'(bz[1]); dc += int'(dn[1]);
            if (!dr[1] && din[1] == 7'h15) hc++;
            tick();
        end
        chk("t2_busy_cycles", 32'(bc), 32'd8);
        chk("t2_done_cycles", 32'(dc), 32'd1);
        chk("t2_hold_cycles", 32'(hc), 32'd4);

        // Loop mode, then stop.
        loop_en = 1'b1; play_len = 8'd3; start = 1'b1;
        tick(); start = 1'b0;
        repeat (6) tick();
        chk("t3_idx_before_wrap", 32'(vi[0]), 32'd2);
        tick();
        chk("t3_idx_wrapped", 32'(vi[0]), 32'd0);
        repeat (2) tick();
        chk("t3_loop_cnt", 32'(lc[0]), 32'd3);
        stop = 1'b1;
        tick(); stop = 1'b0; loop_en = 1'b0;
        chk("t3_stopped_busy", 32'(bz[0]), 32'd0);
        chk("t3_held_loop_cnt", 32'(lc[0]), 32'd3);
        chk("t3_u4_loop_cnt", 32'(lc[1]), 32'd0);
        dc = 0;
        repeat (3) begin dc += int'(dn[0]) + int'(dn[1]); tick(); end
        chk("t3_no_done", 32'(dc), 32'd0);

        // Zero-length playback.
        play_len = 8'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("t4_done_early", 32'(dn[0]), 32'd0);
        tick();
        chk("t4_done", 32'(dn[0]), 32'd1); chk("t4_dut_in", 32'(din[0]), 32'd0);
        chk("t4_busy", 32'(bz[0]), 32'd0);
        tick();
        chk("t4_done_once", 32'(dn[0]), 32'd0);

        // start together with stop is ignored.
        play_len = 8'd3; start = 1'b1; stop = 1'b1;
        tick(); start = 1'b0; stop = 1'b0;
        chk("t5_startstop_busy", 32'(bz[0]), 32'd0);
        tick();
        chk("t5_startstop_done", 32'(dn[0]), 32'd0);

        // Load during playback ignored; reset mid-playback.
        start = 1'b1;
        tick(); start = 1'b0;
        load_we = 1'b1; load_addr = 7'd1; load_data = 8'h2A;
        tick(); load_we = 1'b0;
        tick();
        chk("t6_idx1", 32'(vi[0]), 32'd1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk_reset_vals("t6_midrun_reset");
        tick();
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("t6_replay_rst", 32'(dr[0]), 32'd0); chk("t6_replay_in", 32'(din[0]), 32'h15);
        repeat (16) tick();

        // Signature over a constant response.
        dut_out = 19'h00001; play_len = 8'd2; start = 1'b1;
        tick(); start = 1'b0;
        repeat (12) tick();
`ifdef VECTOR_PLAYER_SIG_EN
        chk("t7_sig_u1", 32'(sg[0]), 32'h3); chk("t7_sig_u4", 32'(sg[1]), 32'h3);
`else
        chk("t7_sig_u1", 32'(sg[0]), 32'h0); chk("t7_sig_u4", 32'(sg[1]), 32'h0);
`endif

        // play_len beyond DEPTH is clamped.
        dut_out = 19'h2A5C3; play_len = 8'd200; start = 1'b1;
        tick(); start = 1'b0;
        repeat (122) tick();
        chk("t8_u1_still_busy", 32'(bz[0]), 32'd1);
        repeat (4) tick();
        chk("t8_u1_clamped_end", 32'(bz[0]), 32'd0);
        repeat (384) tick();
        chk("t8_loop_cnt_u1", 32'(lc[0]), 32'd1); chk("t8_loop_cnt_u4", 32'(lc[1]), 32'd1);

        // loop_cnt saturation.
        loop_en = 1'b1; play_len = 8'd1; start = 1'b1;
        tick(); start = 1'b0;
        repeat (1100) tick();
        chk("t9_sat_u1", 32'(lc[0]), 32'd255); chk("t9_sat_u4", 32'(lc[1]), 32'd255);
        stop = 1'b1;
        tick(); stop = 1'b0; loop_en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
